riscv_instr_cfg_sink: RTL and testbench

//   Receive side of the leaf instruction-config write stream (byte address, byte data, write enable).
//   The leaf interface drives this stream while the core is held in reset.

---
 rtl/riscv_cfg_pkg.sv | 30 +++
 rtl/riscv_instr_cfg_sink.sv | 184 ++++++++++++++++++
 tb/tb_riscv_instr_cfg_sink.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_cfg_pkg.sv
// ----------------------------------------------------------------------------
// riscv_cfg_pkg
//   Shared definitions for the instruction-config write sink: assembly-FSM
//   state encoding, stream/word widths and the byte-lane merge helper.
// ----------------------------------------------------------------------------
package riscv_cfg_pkg;

    localparam int LANE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int CFG_ADDR_W = 24;

    // IDLE holds no bytes; COLLECT holds a partial word (be_buf != 0).
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } cfg_state_t;

    // Return word with byte lane 'lane' replaced by 'data' (little-endian).
    function automatic logic [WORD_W-1:0] lane_insert(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        lane,
        input logic [LANE_W-1:0] data
    );
        logic [WORD_W-1:0] result;
        result = word;
        result[lane*LANE_W +: LANE_W] = data;
        return result;
    endfunction

endpackage

// File: rtl/riscv_instr_cfg_sink.sv
// ----------------------------------------------------------------------------
// riscv_instr_cfg_sink
//   Receives the byte-wide config write stream that loads instruction memory
//   while the core is held in reset, packs little-endian bytes into 32-bit
//   words and issues byte-enabled writes to the instruction BRAM.
//
//   A partial word is written out when the stream moves to another word, when
//   all four lanes are filled, or after IDLE_FLUSH cycles without a byte.
//
// Ports
//   clk_user       in   user clock, all logic on its rising edge
//   reset          in   asynchronous active-high reset
//   cfg_addr       in   byte address of the config write (24 bit)
//   cfg_din        in   config data byte
//   cfg_wr_en      in   config write strobe, one byte per cycle, no stall
//   mem_we         out  BRAM byte enables, nonzero for exactly one cycle/write
//   mem_addr       out  BRAM word address
//   mem_wdata      out  BRAM write data
//   cfg_busy       out  a partial word is being held
//   cfg_err        out  sticky: an out-of-range byte was dropped
//   words_written  out  number of BRAM write cycles, saturating
// ----------------------------------------------------------------------------
module riscv_instr_cfg_sink
    import riscv_cfg_pkg::*;
#(
    parameter int MEM_SIZE   = 32768,
    parameter int ADDR_BITS  = 13,
    parameter int IDLE_FLUSH = 16
) (
    input  logic                  clk_user,
    input  logic                  reset,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [LANE_W-1:0]     cfg_din,
    input  logic                  cfg_wr_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    output logic                  cfg_busy,
    output logic                  cfg_err,
    output logic [15:0]           words_written
);

    localparam logic [7:0] FLUSH_AT = 8'(IDLE_FLUSH - 1);

    cfg_state_t            state;
    logic [WORD_W-1:0]     word_buf;
    logic [3:0]            be_buf;
    logic [ADDR_BITS-1:0]  cur_waddr;
    logic [7:0]            idle_cnt;

    // Decoded view of the incoming byte.
    logic                  in_range;
    logic                  accept;
    logic [1:0]            lane;
    logic [3:0]            lane_bit;
    logic [ADDR_BITS-1:0]  in_waddr;
    logic                  same_word;

    assign in_range  = ({8'd0, cfg_addr} < 32'(MEM_SIZE));
    assign accept    = cfg_wr_en && in_range;
    assign lane      = cfg_addr[1:0];
    assign lane_bit  = 4'b0001 << lane;
    assign in_waddr  = cfg_addr[ADDR_BITS+1:2];
    assign same_word = (in_waddr == cur_waddr);

    // Next-state of the buffer and the write (if any) to issue this edge.
    cfg_state_t            nxt_state;
    logic [WORD_W-1:0]     nxt_word;
    logic [3:0]            nxt_be;
    logic [ADDR_BITS-1:0]  nxt_waddr;
    logic [7:0]            nxt_idle;
    logic                  emit;
    logic [3:0]            emit_we;
    logic [WORD_W-1:0]     emit_data;
    logic [WORD_W-1:0]     merged_word;
    logic [3:0]            merged_be;

    assign merged_word = lane_insert(word_buf, lane, cfg_din);
    assign merged_be   = be_buf | lane_bit;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        nxt_state = state;
        nxt_word  = word_buf;
        nxt_be    = be_buf;
        nxt_waddr = cur_waddr;
        nxt_idle  = idle_cnt;
        emit      = 1'b0;
        emit_we   = be_buf;
        emit_data = word_buf;

        case (state)
            IDLE: begin
                if (accept) begin
                    nxt_word  = lane_insert('0, lane, cfg_din);
                    nxt_be    = lane_bit;
                    nxt_waddr = in_waddr;
                    nxt_idle  = 8'd0;
                    nxt_state = COLLECT;
                end
            end

            COLLECT: begin
                if (accept && same_word) begin
                    nxt_idle = 8'd0;
                    if (merged_be == 4'hF) begin
                        // Word complete: write it and start from empty.
                        emit      = 1'b1;
                        emit_we   = 4'hF;
                        emit_data = merged_word;
                        nxt_word  = '0;
                        nxt_be    = 4'h0;
                        nxt_state = IDLE;
                    end else begin
                        nxt_word = merged_word;
                        nxt_be   = merged_be;
                    end
                end else if (accept) begin
                    // Stream moved on: write the old partial word and reload
                    // with the new byte on the same edge, so no byte is lost.
                    emit      = 1'b1;
                    nxt_word  = lane_insert('0, lane, cfg_din);
                    nxt_be    = lane_bit;
                    nxt_waddr = in_waddr;
                    nxt_idle  = 8'd0;
                end else if (idle_cnt == FLUSH_AT) begin
                    // Timeout is only reached when no in-range byte arrives,
                    // so a coinciding byte always takes the rules above.
                    emit      = 1'b1;
                    nxt_word  = '0;
                    nxt_be    = 4'h0;
                    nxt_idle  = 8'd0;
                    nxt_state = IDLE;
                end else begin
                    // Dropped out-of-range bytes also land here: they do not
                    // restart the idle timer.
                    nxt_idle = idle_cnt + 8'd1;
                end
            end

            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_user or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            word_buf      <= '0;
            be_buf        <= 4'h0;
            cur_waddr     <= '0;
            idle_cnt      <= 8'd0;
            mem_we        <= 4'h0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            cfg_err       <= 1'b0;
            words_written <= 16'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            state     <= nxt_state;
            word_buf  <= nxt_word;
            be_buf    <= nxt_be;
            cur_waddr <= nxt_waddr;
            idle_cnt  <= nxt_idle;

            mem_we <= emit ? emit_we : 4'h0;
            if (emit) begin
                mem_addr  <= cur_waddr;
                mem_wdata <= emit_data;
                if (words_written != 16'hFFFF) begin
                    words_written <= words_written + 16'd1;
                end
            end

            if (cfg_wr_en && !in_range) begin
                cfg_err <= 1'b1;
            end
        end
    end

    assign cfg_busy = (be_buf != 4'h0);

endmodule

// File: tb/tb_riscv_instr_cfg_sink.sv
// ----------------------------------------------------------------------------
// tb_riscv_instr_cfg_sink
//   Directed bench for riscv_instr_cfg_sink. Each expected BRAM write (enables,
//   address, data, cycle in which it must be visible) is queued when the
//   stimulus that causes it is driven, and popped by a monitor that watches
//   mem_we on the falling edge.
// ----------------------------------------------------------------------------
module tb_riscv_instr_cfg_sink;

    localparam int MEM_SIZE   = 32768;
    localparam int ADDR_BITS  = 13;
    localparam int IDLE_FLUSH = 16;

    logic                 clk_user = 1'b0;
    logic                 reset;
    logic [23:0]          cfg_addr;
    logic [7:0]           cfg_din;
    logic                 cfg_wr_en;
    logic [3:0]           mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [31:0]          mem_wdata;
    logic                 cfg_busy;
    logic                 cfg_err;
    logic [15:0]          words_written;

    riscv_instr_cfg_sink #(
        .MEM_SIZE   (MEM_SIZE),
        .ADDR_BITS  (ADDR_BITS),
        .IDLE_FLUSH (IDLE_FLUSH)
    ) dut (
        .clk_user      (clk_user),
        .reset         (reset),
        .cfg_addr      (cfg_addr),
        .cfg_din       (cfg_din),
        .cfg_wr_en     (cfg_wr_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cfg_busy      (cfg_busy),
        .cfg_err       (cfg_err),
        .words_written (words_written)
    );

    always #5 clk_user = ~clk_user;

    typedef struct {
        logic [3:0]           we;
        logic [ADDR_BITS-1:0] addr;
        logic [31:0]          data;
        int                   vis;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          last_cyc;
    logic [15:0] ww_model = 16'd0;

    always @(posedge clk_user) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] we, input logic [ADDR_BITS-1:0] addr,
                        input logic [31:0] data, input int vis);
        exp_t e;
        e.we = we; e.addr = addr; e.data = data; e.vis = vis;
        sb.push_back(e);
    endtask

    // Drive one byte for one cycle; last_cyc records the launch cycle.
    task automatic send(input logic [23:0] a, input logic [7:0] d);
        @(negedge clk_user);
        cfg_addr  = a;
        cfg_din   = d;
        cfg_wr_en = 1'b1;
        last_cyc  = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_user);
            cfg_wr_en = 1'b0;
        end
    endtask

    // Scoreboard monitor: every write must match the head of the queue.
    always @(negedge clk_user) begin
        exp_t e;
        if (!reset && mem_we !== 4'h0) begin
            ww_model = (ww_model == 16'hFFFF) ? ww_model : ww_model + 16'd1;
            check("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("mem_we",    32'(mem_we),   32'(e.we));
                check("mem_addr",  32'(mem_addr), 32'(e.addr));
                check("mem_wdata", mem_wdata,     e.data);
                check("latency",   32'(cyc),      32'(e.vis));
            end
            check("words_written", 32'(words_written), 32'(ww_model));
        end
    end

    initial begin
        reset     = 1'b1;
        cfg_addr  = '0;
        cfg_din   = '0;
        cfg_wr_en = 1'b0;
        repeat (3) @(negedge clk_user);
        check("rst_mem_we",   32'(mem_we),        32'd0);
        check("rst_mem_addr", 32'(mem_addr),      32'd0);
        check("rst_wdata",    mem_wdata,          32'd0);
        check("rst_busy",     32'(cfg_busy),      32'd0);
        check("rst_err",      32'(cfg_err),       32'd0);
        check("rst_count",    32'(words_written), 32'd0);
        reset = 1'b0;
        idle(2);

        // 1: full word, one cycle after the last byte
        send(24'h000100, 8'h93);
        send(24'h000101, 8'h00);
        send(24'h000102, 8'h10);
        send(24'h000103, 8'h00);
        push(4'hF, 13'h040, 32'h00100093, last_cyc + 1);
        idle(3);
        check("t1_busy",  32'(cfg_busy),      32'd0);
        check("t1_count", 32'(words_written), 32'd1);

        // 2: address change flushes partial word, then idle timeout
        send(24'h000010, 8'hAA);
        send(24'h000011, 8'hBB);
        send(24'h000020, 8'hCC);
        push(4'b0011, 13'h004, 32'h0000BBAA, last_cyc + 1);
        push(4'b0001, 13'h008, 32'h000000CC, last_cyc + 1 + IDLE_FLUSH);
        idle(2);
        check("t2_busy_held", 32'(cfg_busy), 32'd1);
        idle(IDLE_FLUSH + 2);
        check("t2_busy_clear", 32'(cfg_busy), 32'd0);

        // 3: out-of-range drops (first address past the end, and an alias
        // of word 1), then in-range traffic including the last byte
        send(24'h008000, 8'hEE);
        send(24'h010004, 8'hEF);
        idle(2);
        check("t3_err",  32'(cfg_err),  32'd1);
        check("t3_busy", 32'(cfg_busy), 32'd0);
        send(24'h000200, 8'h01);
        send(24'h000201, 8'h02);
        send(24'h000202, 8'h03);
        send(24'h000203, 8'h04);
        push(4'hF, 13'h080, 32'h04030201, last_cyc + 1);
        send(24'h007FFF, 8'h9C);
        push(4'b1000, 13'h1FFF, 32'h9C000000, last_cyc + 1 + IDLE_FLUSH);
        idle(IDLE_FLUSH + 3);
        check("t3_err_sticky", 32'(cfg_err), 32'd1);

        // 4: reset mid-word discards the partial word
        send(24'h000300, 8'h5A);
        send(24'h000301, 8'hA5);
        @(negedge clk_user);
        cfg_wr_en = 1'b0;
        reset     = 1'b1;
        ww_model  = 16'd0;
        idle(2);
        reset = 1'b0;
        idle(1);
        check("t4_busy",  32'(cfg_busy),      32'd0);
        check("t4_count", 32'(words_written), 32'd0);
        check("t4_err",   32'(cfg_err),       32'd0);
        idle(IDLE_FLUSH + 4);
        check("t4_no_write", 32'(words_written), 32'd0);

        // 5: eight bytes back-to-back, two full words
        for (int i = 0; i < 8; i++) begin
            send(24'(i), 8'(8'h10 + i));
            if (i == 3) push(4'hF, 13'h000, 32'h13121110, last_cyc + 1);
            if (i == 7) push(4'hF, 13'h001, 32'h17161514, last_cyc + 1);
        end
        idle(3);

        // 6: repeated lane overwrites
        send(24'h000000, 8'h11);
        send(24'h000000, 8'h22);
        send(24'h000001, 8'h33);
        send(24'h000002, 8'h44);
        send(24'h000003, 8'h55);
        push(4'hF, 13'h000, 32'h55443322, last_cyc + 1);
        idle(3);

        // 7: byte on the timeout cycle merges instead of flushing
        send(24'h000040, 8'hA1);
        idle(IDLE_FLUSH - 1);
        send(24'h000041, 8'hA2);
        push(4'b0011, 13'h010, 32'h0000A2A1, last_cyc + 1 + IDLE_FLUSH);
        idle(IDLE_FLUSH + 3);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk_user);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
